// File: rtl/fpu_issue_pipe.sv
// Multi-cycle FP execution pipe with a destination scoreboard. Results shift through
// STAGES registers toward writeback and are forwarded back to execute while in flight.
module fpu_issue_pipe #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int STAGES      = 3,
  parameter int ZERO_REG_EN = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [ADDR_W-1:0]     issue_rd,
  input  logic [DATA_W-1:0]     issue_data,
  input  logic [ADDR_W-1:0]     rs1_addr,
  input  logic [ADDR_W-1:0]     rs2_addr,
  output logic                  fwd1_hit,
  output logic [DATA_W-1:0]     fwd1_data,
  output logic                  fwd2_hit,
  output logic [DATA_W-1:0]     fwd2_data,
  input  logic                  flush,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [ADDR_W-1:0]     wb_rd,
  output logic [DATA_W-1:0]     wb_data,
  output logic [2**ADDR_W-1:0]  pending,
  output logic [3:0]            inflight
);

  localparam int LAST = STAGES - 1;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t st [STAGES];
  entry_t in_entry;
  logic   advance;
  logic   waw;
  logic   accept;

  // An entry takes part in scoreboarding and forwarding unless it targets the hardwired zero register.
  function automatic logic tracked(entry_t e);
    return e.valid && !((ZERO_REG_EN != 0) && (e.rd == '0));
  endfunction

  assign wb_valid = st[LAST].valid;
  assign wb_rd    = st[LAST].rd;
  assign wb_data  = st[LAST].data;

  assign advance     = !(wb_valid && !wb_ready);
  assign waw         = pending[issue_rd];
  assign issue_ready = advance && !waw && !flush;
  assign accept      = issue_valid && issue_ready;
  assign in_entry    = '{valid: 1'b1, rd: issue_rd, data: issue_data};

  // Scoreboard is derived from the stage contents, so set, clear and flush stay consistent by construction.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pending  = '0;
    inflight = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (tracked(st[i])) pending[st[i].rd] = 1'b1;
      if (st[i].valid)    inflight = inflight + 4'd1;
    end
  end

  // WAW blocking guarantees at most one match per lookup, so an OR of gated data is a one-hot mux.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (tracked(st[i]) && (st[i].rd == rs1_addr)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = fwd1_data | st[i].data;
      end
      if (tracked(st[i]) && (st[i].rd == rs2_addr)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = fwd2_data | st[i].data;
      end
    end
  end

  // Flush kills every speculative stage; the last stage is only ever vacated by its own commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) st[i] <= '0;
    end else if (advance) begin
      // NOTE: state registers use non-blocking assignment so every stage samples its neighbour's pre-edge value.
      st[0] <= accept ? in_entry : '0;
      for (int i = 1; i < STAGES; i++) st[i] <= flush ? '0 : st[i-1];
    end else if (flush) begin
      for (int i = 0; i < LAST; i++) st[i] <= '0;
    end
  end

endmodule

// File: tb/tb_fpu_issue_pipe.sv
// Self-checking bench for fpu_issue_pipe: an op-list reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fpu_issue_pipe;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int STAGES = 3;
  localparam int NREG   = 2**ADDR_W;

  logic              clk, reset;
  logic              issue_valid, issue_ready;
  logic [ADDR_W-1:0] issue_rd, rs1_addr, rs2_addr, wb_rd;
  logic [DATA_W-1:0] issue_data, fwd1_data, fwd2_data, wb_data;
  logic              fwd1_hit, fwd2_hit, flush, wb_valid, wb_ready;
  logic [NREG-1:0]   pending;
  logic [3:0]        inflight;

  fpu_issue_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STAGES(STAGES), .ZERO_REG_EN(0)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rd(issue_rd), .issue_data(issue_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data),
    .pending(pending), .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: ordered list of in-flight ops, oldest first, each with its depth in the pipe.
  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    int                pos;
  } op_t;

  op_t mq[$];

  function automatic bit m_wb_valid();
    return (mq.size() > 0) && (mq[0].pos == STAGES - 1);
  endfunction

  function automatic logic [NREG-1:0] m_pending();
    logic [NREG-1:0] p = '0;
    foreach (mq[i]) p[mq[i].rd] = 1'b1;
    return p;
  endfunction

  function automatic void m_fwd(input logic [ADDR_W-1:0] a, output logic hit, output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
    foreach (mq[i]) if (mq[i].rd == a) begin hit = 1'b1; d = mq[i].data; end
  endfunction

  function automatic bit m_issue_ready();
    bit adv = !(m_wb_valid() && !wb_ready);
    logic [NREG-1:0] p = m_pending();
    return adv && !p[issue_rd] && !flush;
  endfunction

  task automatic model_step();
    bit  wbv    = m_wb_valid();
    bit  commit = wbv && wb_ready;
    bit  adv    = !(wbv && !wb_ready);
    bit  acc    = issue_valid && m_issue_ready();
    op_t keep[$];
    if (commit) void'(mq.pop_front());
    if (flush) begin
      foreach (mq[i]) if (mq[i].pos == STAGES - 1) keep.push_back(mq[i]);
      mq = keep;
    end
    if (adv) foreach (mq[i]) mq[i].pos++;
    if (acc) mq.push_back('{rd: issue_rd, data: issue_data, pos: 0});
  endtask

  always @(posedge clk) if (reset) model_step();

  task automatic compare_model();
    logic             h;
    logic [DATA_W-1:0] d;
    check("wb_valid", wb_valid, m_wb_valid());
    if (m_wb_valid()) begin
      check("wb_rd", wb_rd, mq[0].rd);
      check("wb_data", wb_data, mq[0].data);
    end
    check("pending", pending, m_pending());
    check("inflight", inflight, mq.size());
    check("issue_ready", issue_ready, m_issue_ready());
    m_fwd(rs1_addr, h, d);
    check("fwd1_hit", fwd1_hit, h);
    check("fwd1_data", fwd1_data, d);
    m_fwd(rs2_addr, h, d);
    check("fwd2_hit", fwd2_hit, h);
    check("fwd2_data", fwd2_data, d);
  endtask

  // One cycle: drive inputs after the falling edge, then compare against the model mid-cycle.
  task automatic drive(input logic iv, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data,
                       input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2,
                       input logic fl, input logic wr);
    @(negedge clk);
    issue_valid = iv; issue_rd = rd; issue_data = data;
    rs1_addr = r1; rs2_addr = r2; flush = fl; wb_ready = wr;
    #1;
    compare_model();
  endtask

  task automatic idle(input logic wr);
    drive(1'b0, '0, '0, '0, '0, 1'b0, wr);
  endtask

  int blocked;

  initial begin
    reset = 1'b0; issue_valid = 1'b0; issue_rd = '0; issue_data = '0;
    rs1_addr = '0; rs2_addr = '0; flush = 1'b0; wb_ready = 1'b1;
    #2;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_pending", pending, 0);
    check("rst_inflight", inflight, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_fwd", {fwd1_hit, fwd2_hit, fwd1_data, fwd2_data}, 0);
    @(negedge clk);
    reset = 1'b1;

    // Latency: accepted in cycle 0, visible at writeback in cycle 3.
    drive(1'b1, 5'd5, 32'h3F800000, '0, '0, 1'b0, 1'b1);
    check("lat_ready", issue_ready, 1);
    idle(1'b1);
    check("lat_c1_pend", pending[5], 1);
    check("lat_c1_wbv", wb_valid, 0);
    idle(1'b1);
    check("lat_c2_pend", pending[5], 1);
    check("lat_c2_wbv", wb_valid, 0);
    idle(1'b1);
    check("lat_c3_wbv", wb_valid, 1);
    check("lat_c3_rd", wb_rd, 5);
    check("lat_c3_data", wb_data, 32'h3F800000);
    check("lat_c3_pend", pending[5], 1);
    idle(1'b1);
    check("lat_c4_pend", pending[5], 0);
    check("lat_c4_wbv", wb_valid, 0);

    // Forwarding from stage 1.
    drive(1'b1, 5'd9, 32'h40490FDB, '0, '0, 1'b0, 1'b1);
    idle(1'b1);
    drive(1'b0, '0, '0, 5'd10, 5'd9, 1'b0, 1'b1);
    check("fwd2_hit_lit", fwd2_hit, 1);
    check("fwd2_data_lit", fwd2_data, 32'h40490FDB);
    check("fwd1_hit_lit", fwd1_hit, 0);
    check("fwd1_data_lit", fwd1_data, 0);
    repeat (3) idle(1'b1);

    // WAW: the second write to rd 7 waits until the first has committed.
    drive(1'b1, 5'd7, 32'hAAAA0001, '0, '0, 1'b0, 1'b1);
    blocked = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'd7, 32'hBBBB0002, '0, '0, 1'b0, 1'b1);
      if (issue_ready) break;
      blocked++;
    end
    check("waw_blocked_cycles", blocked, 3);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    check("waw_second_wb", {wb_valid, wb_data}, {1'b1, 32'hBBBB0002});
    idle(1'b1);

    // Back-pressure then drain in order.
    drive(1'b1, 5'd11, 32'h11, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 5'd12, 32'h12, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 5'd13, 32'h13, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 5'd14, 32'h14, '0, '0, 1'b0, 1'b0);
    check("bp_full_ready", issue_ready, 0);
    check("bp_inflight", inflight, 3);
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
    check("bp_drain0", wb_rd, 11);
    idle(1'b1);
    check("bp_drain1", wb_rd, 12);
    idle(1'b1);
    check("bp_drain2", wb_rd, 13);
    idle(1'b1);
    check("bp_empty", inflight, 0);

    // Flush with a full pipe: only the oldest (rd 3) survives.
    drive(1'b1, 5'd3, 32'h33, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 5'd2, 32'h22, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 5'd1, 32'h11, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 5'd4, 32'h44, '0, '0, 1'b1, 1'b0);
    check("fl_ready", issue_ready, 0);
    check("fl_pre_inflight", inflight, 3);
    idle(1'b0);
    check("fl_pending", pending, 32'h8);
    check("fl_inflight", inflight, 1);
    check("fl_wb_rd", wb_rd, 3);
    idle(1'b1);
    check("fl_commit", {wb_valid, wb_data}, {1'b1, 32'h33});
    idle(1'b1);
    check("fl_after", inflight, 0);

    // Asynchronous reset between edges with two entries in flight.
    drive(1'b1, 5'd20, 32'h20, '0, '0, 1'b0, 1'b1);
    drive(1'b1, 5'd21, 32'h21, '0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 5'd20, '0, 1'b0, 1'b1);
    check("ar_pre_inflight", inflight, 2);
    #2;
    reset = 1'b0;
    #1;
    check("ar_wb_valid", wb_valid, 0);
    check("ar_pending", pending, 0);
    check("ar_inflight", inflight, 0);
    check("ar_fwd1", fwd1_hit, 0);
    mq.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      check("ar_no_wb", wb_valid, 0);
    end

    // Randomized traffic over a small register window to provoke WAW and forwarding hits.
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), $urandom(),
            ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
